// File: rtl/mux_scan_serializer_pkg.sv
// rtl/mux_scan_serializer_pkg.sv - shared constants for the mux scan serializer
package mux_scan_serializer_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SHIFT = 1'b1;

    localparam int WIDTH_DEFAULT = 7;
    localparam int DIV_DEFAULT   = 25000000;
    localparam int SEL_W_DEFAULT = $clog2(WIDTH_DEFAULT);

    // Rate counter width; a one-cycle period still needs a 1-bit counter
    function automatic int cnt_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/mux_scan_serializer_rate_tick_divider.sv
// rtl/mux_scan_serializer_rate_tick_divider.sv - down-counter producing one tick per DIV enabled cycles
module rate_tick_divider
    import mux_scan_serializer_pkg::*;
#(
    parameter int DIV   = DIV_DEFAULT,
    parameter int CNT_W = cnt_width(DIV)
) (
    input  logic Clock_i,
    input  logic Resetn_i,
    input  logic Clear_i,
    input  logic Enable_i,
    output logic Tick_o
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (Clear_i) begin
            cnt_d = RELOAD;
        end else if (Enable_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge Clock_i or negedge Resetn_i) begin
        if (!Resetn_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign Tick_o = Enable_i && (cnt_q == '0);

endmodule

// File: rtl/mux_scan_serializer.sv
// rtl/mux_scan_serializer.sv - 7-to-1 mux select sequencer with timed serial output
// Optional SERIAL_LOOP_EN adds Loop_i to repeat the held word without returning to idle.
module mux_scan_serializer
    import mux_scan_serializer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int DIV   = DIV_DEFAULT,
    parameter int SEL_W = SEL_W_DEFAULT,
    parameter int CNT_W = cnt_width(DIV)
) (
    input  logic             Clock_i,
    input  logic             Resetn_i,
    input  logic             Start_i,
    input  logic [WIDTH-1:0] Data_i,
`ifdef SERIAL_LOOP_EN
    input  logic             Loop_i,
`endif
    output logic             Ready_o,
    output logic [SEL_W-1:0] MuxSelect_o,
    output logic             SerialOut_o,
    output logic             Done_o
);

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(WIDTH - 1);

    logic             state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [SEL_W-1:0] sel_q, sel_d, sel_inc;
    logic             ser_q, ser_d;
    logic             done_q, done_d;
    logic             tick, accept, loop_en;

`ifdef SERIAL_LOOP_EN
    assign loop_en = Loop_i;
`else
    assign loop_en = 1'b0;
`endif

    assign accept  = (state_q == ST_IDLE) && Start_i;
    assign sel_inc = sel_q + SEL_W'(1);

    // Reload on capture and on every bit advance so each bit lasts DIV cycles
    rate_tick_divider #(
        .DIV   (DIV),
        .CNT_W (CNT_W)
    ) u_rate (
        .Clock_i  (Clock_i),
        .Resetn_i (Resetn_i),
        .Clear_i  (accept || tick),
        .Enable_i (state_q == ST_SHIFT),
        .Tick_o   (tick)
    );

    always_ff @(posedge Clock_i or negedge Resetn_i) begin
        if (!Resetn_i) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            sel_q   <= '0;
            ser_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            sel_q   <= sel_d;
            ser_q   <= ser_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        sel_d   = sel_q;
        ser_d   = ser_q;
        done_d  = 1'b0;
        if (state_q == ST_IDLE) begin
            if (Start_i) begin
                hold_d  = Data_i;
                sel_d   = '0;
                ser_d   = Data_i[0];
                state_d = ST_SHIFT;
            end
        end else if (tick) begin
            if (sel_q != LAST_SEL) begin
                sel_d = sel_inc;
                ser_d = hold_q[sel_inc];
            end else begin
                done_d = 1'b1;
                sel_d  = '0;
                if (loop_en) begin
                    ser_d = hold_q[0];
                end else begin
                    ser_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
        end
    end

    always_comb begin
        Ready_o     = (state_q == ST_IDLE);
        MuxSelect_o = sel_q;
        SerialOut_o = ser_q;
        Done_o      = done_q;
    end

endmodule

// File: tb/tb_mux_scan_serializer.sv
// tb/tb_mux_scan_serializer.sv - directed self-checking bench for mux_scan_serializer
module tb_mux_scan_serializer;

    logic       clk;
    logic       resetn;
    logic       start4, start2, start1;
    logic [6:0] data4, data2, data1;
    logic       ready4, ready2, ready1;
    logic [2:0] sel4, sel2, sel1;
    logic       ser4, ser2, ser1;
    logic       done4, done2, done1;
    logic       loop1;
    int         passed;
    int         total;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mux_scan_serializer #(.WIDTH(7), .DIV(4)) u_div4 (
        .Clock_i(clk), .Resetn_i(resetn), .Start_i(start4), .Data_i(data4),
`ifdef SERIAL_LOOP_EN
        .Loop_i(1'b0),
`endif
        .Ready_o(ready4), .MuxSelect_o(sel4), .SerialOut_o(ser4), .Done_o(done4)
    );

    mux_scan_serializer #(.WIDTH(7), .DIV(2)) u_div2 (
        .Clock_i(clk), .Resetn_i(resetn), .Start_i(start2), .Data_i(data2),
`ifdef SERIAL_LOOP_EN
        .Loop_i(1'b0),
`endif
        .Ready_o(ready2), .MuxSelect_o(sel2), .SerialOut_o(ser2), .Done_o(done2)
    );

    mux_scan_serializer #(.WIDTH(7), .DIV(1)) u_div1 (
        .Clock_i(clk), .Resetn_i(resetn), .Start_i(start1), .Data_i(data1),
`ifdef SERIAL_LOOP_EN
        .Loop_i(loop1),
`endif
        .Ready_o(ready1), .MuxSelect_o(sel1), .SerialOut_o(ser1), .Done_o(done1)
    );

    // Expected {Ready, MuxSelect, SerialOut, Done} n edges after the accepted Start edge
    function automatic logic [5:0] exp_frame(input logic [6:0] d, input int div, input int n);
        int b;
        if (n < 7 * div) begin
            b = n / div;
            return {1'b0, 3'(b), d[b], 1'b0};
        end else if (n == 7 * div) begin
            return 6'b100001;
        end
        return 6'b100000;
    endfunction

    task automatic test_reset();
        resetn = 1'b0;
        start4 = 1'b1; start2 = 1'b1; start1 = 1'b1;
        data4 = 7'h7F; data2 = 7'h7F; data1 = 7'h7F;
        loop1 = 1'b0;
        #1;
        for (int c = 0; c < 4; c++) begin
            total++;
            if ({ready4, sel4, ser4, done4} !== 6'b100000)
                $display("FAIL reset_div4 c=%0d got=%b exp=%b", c, {ready4, sel4, ser4, done4}, 6'b100000);
            else passed++;
            total++;
            if ({ready2, sel2, ser2, done2} !== 6'b100000)
                $display("FAIL reset_div2 c=%0d got=%b exp=%b", c, {ready2, sel2, ser2, done2}, 6'b100000);
            else passed++;
            total++;
            if ({ready1, sel1, ser1, done1} !== 6'b100000)
                $display("FAIL reset_div1 c=%0d got=%b exp=%b", c, {ready1, sel1, ser1, done1}, 6'b100000);
            else passed++;
            @(negedge clk);
        end
        start4 = 1'b0; start2 = 1'b0; start1 = 1'b0;
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_frame_div4();
        logic [6:0] d;
        logic [5:0] exp;
        d = 7'b1011001;
        start4 = 1'b1; data4 = d;
        @(negedge clk);
        start4 = 1'b0;
        for (int n = 0; n < 31; n++) begin
            exp = exp_frame(d, 4, n);
            total++;
            if ({ready4, sel4, ser4, done4} !== exp)
                $display("FAIL frame_div4 n=%0d got=%b exp=%b", n, {ready4, sel4, ser4, done4}, exp);
            else passed++;
            @(negedge clk);
        end
    endtask

    task automatic test_start_ignored();
        logic [6:0] d;
        logic [5:0] exp;
        d = 7'b1011001;
        start4 = 1'b1; data4 = d;
        @(negedge clk);
        start4 = 1'b0;
        for (int n = 0; n < 31; n++) begin
            exp = exp_frame(d, 4, n);
            total++;
            if ({ready4, sel4, ser4, done4} !== exp)
                $display("FAIL start_ignored n=%0d got=%b exp=%b", n, {ready4, sel4, ser4, done4}, exp);
            else passed++;
            start4 = (n == 10);
            data4  = (n >= 10) ? 7'h00 : d;
            @(negedge clk);
        end
        start4 = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [6:0] d;
        logic [5:0] exp;
        d = 7'b0000001;
        start2 = 1'b1; data2 = d;
        @(negedge clk);
        for (int n = 0; n < 45; n++) begin
            exp = exp_frame(d, 2, n % 15);
            total++;
            if ({ready2, sel2, ser2, done2} !== exp)
                $display("FAIL back_to_back n=%0d got=%b exp=%b", n, {ready2, sel2, ser2, done2}, exp);
            else passed++;
            if (n == 44) start2 = 1'b0;
            @(negedge clk);
        end
        total++;
        if ({ready2, sel2, ser2, done2} !== 6'b100000)
            $display("FAIL back_to_back_stop got=%b exp=%b", {ready2, sel2, ser2, done2}, 6'b100000);
        else passed++;
    endtask

    task automatic test_reset_midframe();
        logic [6:0] d;
        logic [5:0] exp;
        d = 7'b1011001;
        start4 = 1'b1; data4 = d;
        @(negedge clk);
        start4 = 1'b0;
        for (int n = 0; n < 13; n++) begin
            exp = exp_frame(d, 4, n);
            total++;
            if ({ready4, sel4, ser4, done4} !== exp)
                $display("FAIL midframe_pre n=%0d got=%b exp=%b", n, {ready4, sel4, ser4, done4}, exp);
            else passed++;
            @(negedge clk);
        end
        resetn = 1'b0;
        #1;
        total++;
        if ({ready4, sel4, ser4, done4} !== 6'b100000)
            $display("FAIL midframe_async got=%b exp=%b", {ready4, sel4, ser4, done4}, 6'b100000);
        else passed++;
        @(negedge clk);
        resetn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if ({ready4, sel4, ser4, done4} !== 6'b100000)
                $display("FAIL midframe_idle c=%0d got=%b exp=%b", c, {ready4, sel4, ser4, done4}, 6'b100000);
            else passed++;
        end
        d = 7'b0110110;
        start4 = 1'b1; data4 = d;
        @(negedge clk);
        start4 = 1'b0;
        for (int n = 0; n < 30; n++) begin
            exp = exp_frame(d, 4, n);
            total++;
            if ({ready4, sel4, ser4, done4} !== exp)
                $display("FAIL midframe_restart n=%0d got=%b exp=%b", n, {ready4, sel4, ser4, done4}, exp);
            else passed++;
            @(negedge clk);
        end
    endtask

    task automatic test_div1();
        logic [6:0] d;
        logic [5:0] exp;
        d = 7'b1010101;
        start1 = 1'b1; data1 = d;
        @(negedge clk);
        start1 = 1'b0;
        for (int n = 0; n < 10; n++) begin
            exp = exp_frame(d, 1, n);
            total++;
            if ({ready1, sel1, ser1, done1} !== exp)
                $display("FAIL div1 n=%0d got=%b exp=%b", n, {ready1, sel1, ser1, done1}, exp);
            else passed++;
            @(negedge clk);
        end
    endtask

`ifdef SERIAL_LOOP_EN
    task automatic test_loop();
        logic [6:0] d;
        logic [5:0] exp;
        int         m;
        d = 7'b1010101;
        loop1 = 1'b1;
        start1 = 1'b1; data1 = d;
        @(negedge clk);
        start1 = 1'b0;
        for (int n = 0; n < 21; n++) begin
            m   = n % 7;
            exp = {1'b0, 3'(m), d[m], (m == 0) && (n > 0)};
            total++;
            if ({ready1, sel1, ser1, done1} !== exp)
                $display("FAIL loop n=%0d got=%b exp=%b", n, {ready1, sel1, ser1, done1}, exp);
            else passed++;
            if (n == 20) loop1 = 1'b0;
            @(negedge clk);
        end
        total++;
        if ({ready1, sel1, ser1, done1} !== 6'b100001)
            $display("FAIL loop_exit got=%b exp=%b", {ready1, sel1, ser1, done1}, 6'b100001);
        else passed++;
        @(negedge clk);
    endtask
`endif

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_frame_div4();
        test_start_ignored();
        test_back_to_back();
        test_reset_midframe();
        test_div1();
`ifdef SERIAL_LOOP_EN
        test_loop();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mux_scan_serializer.md
Name: mux_scan_serializer

Overview:
Upstream sequencer for the 7-to-1 bit-select mux stage.
- Captures a 7-bit word and drives MuxSelect from 0 to 6 at a divided rate.
- Presents the selected bit on SerialOut, which produces a timed serial bit stream (LED / Morse-style display).
- Uses a ready/start handshake for loading and a one-cycle Done pulse at frame end.

Parameters:
WIDTH, 7, data word width; the mux stage supports at most 7 bits.
DIV, 25000000, clock cycles per bit period; must be at least 1. Use small values in simulation.
SEL_W, 3, width of MuxSelect; equals clog2(WIDTH).
CNT_W, 25, width of the rate counter; equals clog2(DIV), with a minimum of 1.

Ports:
Clock  in  1  system clock, rising edge.
Resetn  in  1  asynchronous, active-low reset.
Start  in  1  load request; sampled only while Ready=1.
Data  in  WIDTH  word to serialize; sampled on the accepted Start edge.
Ready  out  1  high in IDLE; block can accept Start.
MuxSelect  out  SEL_W  index of the bit currently presented.
SerialOut  out  1  current serial bit (registered).
Done  out  1  one-cycle pulse when a frame completes.

Behaviour:
Reset (asynchronous, Resetn=0):
- state=IDLE, hold=0, MuxSelect=0, SerialOut=0, Done=0, rate counter=0.
- Outputs follow reset immediately, without waiting for a clock edge.

States:
- IDLE: Ready=1, SerialOut=0, MuxSelect=0.
- SHIFT: Ready=0.
- Encoding is 1 bit.

IDLE, Start=1 at an edge:
- hold<=Data, MuxSelect<=0, SerialOut<=Data[0], counter<=DIV-1, state<=SHIFT.
- Latency from the Start edge to the first bit on SerialOut is 1 edge.

SHIFT, counter!=0:
- counter<=counter-1; all else holds.

SHIFT, counter==0, MuxSelect<WIDTH-1:
- MuxSelect<=MuxSelect+1, SerialOut<=hold[MuxSelect+1], counter<=DIV-1.

SHIFT, counter==0, MuxSelect==WIDTH-1:
- state<=IDLE, SerialOut<=0, MuxSelect<=0, Done<=1 for exactly one cycle.

Timing and boundary conditions:
- Each bit is held for exactly DIV cycles. A frame occupies WIDTH*DIV cycles of SHIFT.
- Done is visible in the first IDLE cycle, together with Ready=1.
- Start while in SHIFT is ignored. Data changes after capture have no effect.
- Start in the Done cycle is accepted, giving back-to-back frames with one IDLE cycle between them.
- DIV=1: one bit per cycle. The counter reload and compare still apply; DIV=1 is not a special case.
- MuxSelect never exceeds WIDTH-1, so the mux default branch is never exercised.
- Resetn low mid-frame aborts at once to the reset values. No Done pulse is issued for an aborted frame.

Optional Feature:
Macro: SERIAL_LOOP_EN.
- Defined: adds input port Loop (1 bit). At frame end with Loop=1, the block stays in SHIFT with MuxSelect<=0, SerialOut<=hold[0], counter<=DIV-1. It repeats the held word indefinitely. Done still pulses once per completed frame, but Ready stays 0. Deasserting Loop lets the current frame finish normally into IDLE.
- Undefined: no Loop port; behaviour exactly as above.

Decomposition:
- Shared package holds:
  - the state encoding constants ST_IDLE=0 and ST_SHIFT=1,
  - the default DIV value,
  - the helper constant for SEL_W.
- One sub-module, rate_tick_divider:
  - Ports: Clock, Resetn, Clear (reload to DIV-1), Enable; output Tick (high when counter==0 and Enable).
  - Parent uses Tick as the bit-advance strobe.

Test Plan:
- Reset: hold Resetn=0 with Start=1 and Data=7'h7F -> Ready=1, SerialOut=0, MuxSelect=0, Done=0 throughout.
- DIV=4, Start pulse with Data=7'b1011001 -> SerialOut=1,0,0,1,1,0,1, each for 4 cycles. MuxSelect steps 0..6. Done is high for 1 cycle, exactly 28 cycles after the Start edge, with SerialOut=0.
- DIV=4, second Start with Data=7'h00 at cycle 10 of a frame -> ignored; the original bit sequence is unchanged; one Done only.
- DIV=2, Start held high continuously, Data=7'b0000001 -> frames repeat with one IDLE cycle between them. Done pulses every 15 cycles.
- DIV=4, Resetn pulsed low at cycle 13 -> all outputs return to reset values asynchronously; no Done; a new Start after release begins at bit 0.
- DIV=1, Data=7'b1010101 -> 7 consecutive cycles of 1,0,1,0,1,0,1, then Done. With SERIAL_LOOP_EN and Loop=1 -> the pattern repeats with no IDLE gap, and Done pulses every 7 cycles.
